// File: rtl/osg_cfg_pkg.sv
// ============================================================================
// Module : osg_cfg_pkg
// Brief  : Shared constants and state encoding for the config frame loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package osg_cfg_pkg;

    localparam logic [7:0] HDR        = 8'hAA;
    localparam logic [7:0] CMD_LOAD   = 8'h01;
    localparam logic [7:0] CMD_START  = 8'h02;
    localparam logic [7:0] START_BYTE = 8'd255;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CMD  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        PAYLOAD  = 3'd2,
        CHECK    = 3'd3,
        START_WR = 3'd4,
        ERR      = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cfg_gap_timer.sv
// ============================================================================
// Module : cfg_gap_timer
// Brief  : Inter-byte gap counter; flags expiry the cycle the count would
//          reach GAP_CYC unless a clear arrives in that same cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_gap_timer #(
    parameter int GAP_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int c_W = $clog2(GAP_CYC + 1);
    localparam logic [c_W-1:0] c_LAST = c_W'(GAP_CYC - 1);
    localparam logic [c_W-1:0] c_MAX  = c_W'(GAP_CYC);

    logic [c_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || !i_en) begin
            cnt_d = '0;
        end else if (cnt_q != c_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A byte arriving on the expiring cycle wins over the timeout.
    assign o_expire = i_en && !i_clr && (cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/cfg_frame_loader.sv
// ============================================================================
// Module : cfg_frame_loader
// Brief  : Parses UART command frames and sequences writes into the channel
//          configuration RAM. Optional macro: CFG_AUTO_START_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_frame_loader
    import osg_cfg_pkg::*;
#(
    parameter int N_CFG   = 112,
    parameter int GAP_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ram_in,
    output logic [7:0] ram_w_addr,
    output logic       ram_write,
    output logic       ram_read,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam logic [7:0] c_N_CFG = 8'(N_CFG);
`ifdef CFG_AUTO_START_EN
    localparam bit c_AUTO_START = 1'b1;
`else
    localparam bit c_AUTO_START = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] chk_q, chk_d;
    logic       is_start_q, is_start_d;
    logic [7:0] ram_in_q, ram_in_d;
    logic [7:0] addr_q, addr_d;
    logic       ram_write_q, ram_write_d;
    logic       ram_read_q, ram_read_d;
    logic       busy_q, busy_d;
    logic       frame_ok_q, frame_ok_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;

    logic       w_expire;
    logic       w_err_req;
    logic [1:0] w_err_val;
    logic       w_start_req;

    cfg_gap_timer #(
        .GAP_CYC (GAP_CYC)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (rx_valid),
        .i_en     (state_q != IDLE),
        .o_expire (w_expire)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        is_start_d  = is_start_q;
        ram_in_d    = ram_in_q;
        addr_d      = addr_q;
        ram_write_d = 1'b1;
        ram_read_d  = ram_read_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        w_err_req   = 1'b0;
        w_err_val   = ERR_NONE;
        w_start_req = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == HDR) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (w_expire) begin
                    w_err_req = 1'b1;
                    w_err_val = ERR_TMO;
                end else if (rx_valid) begin
                    if (rx_data == CMD_LOAD) begin
                        chk_d      = CMD_LOAD;
                        cnt_d      = 8'd0;
                        is_start_d = 1'b0;
                        ram_read_d = 1'b0;
                        state_d    = PAYLOAD;
                    end else if (rx_data == CMD_START) begin
                        chk_d      = CMD_START;
                        is_start_d = 1'b1;
                        state_d    = CHECK;
                    end else begin
                        w_err_req = 1'b1;
                        w_err_val = ERR_CMD;
                    end
                end
            end
            PAYLOAD: begin
                if (w_expire) begin
                    w_err_req = 1'b1;
                    w_err_val = ERR_TMO;
                end else if (rx_valid) begin
                    // Payload byte k lands at address N_CFG-k (top down).
                    addr_d      = c_N_CFG - cnt_q;
                    ram_in_d    = rx_data;
                    ram_write_d = 1'b0;
                    chk_d       = chk_q ^ rx_data;
                    cnt_d       = cnt_q + 8'd1;
                    if (cnt_q == c_N_CFG - 8'd1) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (w_expire) begin
                    w_err_req = 1'b1;
                    w_err_val = ERR_TMO;
                end else if (rx_valid) begin
                    if (rx_data != chk_q) begin
                        w_err_req = 1'b1;
                        w_err_val = ERR_CHK;
                    end else if (is_start_q || c_AUTO_START) begin
                        w_start_req = 1'b1;
                    end else begin
                        frame_ok_d = 1'b1;
                        ram_read_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            START_WR: state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Pulses are launched on entry so they coincide with START_WR / ERR.
        if (w_start_req) begin
            state_d     = START_WR;
            addr_d      = 8'd0;
            ram_in_d    = START_BYTE;
            ram_write_d = 1'b0;
            ram_read_d  = 1'b1;
            frame_ok_d  = 1'b1;
        end
        if (w_err_req) begin
            state_d     = ERR;
            frame_err_d = 1'b1;
            err_code_d  = w_err_val;
            ram_read_d  = 1'b1;
        end
        if (frame_ok_d) begin
            err_code_d = ERR_NONE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            chk_q       <= 8'd0;
            is_start_q  <= 1'b0;
            ram_in_q    <= 8'd0;
            addr_q      <= 8'd0;
            ram_write_q <= 1'b1;
            ram_read_q  <= 1'b1;
            busy_q      <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            is_start_q  <= is_start_d;
            ram_in_q    <= ram_in_d;
            addr_q      <= addr_d;
            ram_write_q <= ram_write_d;
            ram_read_q  <= ram_read_d;
            busy_q      <= busy_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign ram_in     = ram_in_q;
    assign ram_w_addr = addr_q;
    assign ram_write  = ram_write_q;
    assign ram_read   = ram_read_q;
    assign busy       = busy_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_frame_loader.sv
// ============================================================================
// Module : tb_cfg_frame_loader
// Brief  : Directed self-checking bench for cfg_frame_loader (default build).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfg_frame_loader;

    localparam int N_CFG = 112;
    localparam int GAP   = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] ram_in;
    logic [7:0] ram_w_addr;
    logic       ram_write;
    logic       ram_read;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    cfg_frame_loader #(
        .N_CFG   (N_CFG),
        .GAP_CYC (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .ram_in     (ram_in),
        .ram_w_addr (ram_w_addr),
        .ram_write  (ram_write),
        .ram_read   (ram_read),
        .busy       (busy),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Activity log gathered one delta after every rising edge.
    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int n_ok = 0;
    int n_err = 0;
    int n_rr_bad = 0;

    always @(posedge clk) begin
        #1;
        if (!ram_write) begin
            wr_addr.push_back(ram_w_addr);
            wr_data.push_back(ram_in);
            if (ram_w_addr != 8'd0 && ram_read) n_rr_bad++;
        end
        if (frame_ok)  n_ok++;
        if (frame_err) n_err++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int pat, input int k);
        if (pat == 0) return 8'(k + 1);
        return 8'(255 - k);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // slow_idx >= 0 delays that payload byte so it lands exactly on the
    // cycle the gap count reaches GAP.
    task automatic send_load(input int pat, input bit bad, input int slow_idx);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h01;
        send_byte(8'hAA);
        send_byte(8'h01);
        for (int k = 0; k < N_CFG; k++) begin
            if (k == slow_idx) repeat (GAP - 2) @(negedge clk);
            b = pat_byte(pat, k);
            c = c ^ b;
            send_byte(b);
        end
        send_byte(bad ? (c ^ 8'h01) : c);
    endtask

    task automatic verify_load(input string tag, input int base, input int pat);
        int bad;
        bad = 0;
        check_eq({tag, "_nwr"}, wr_addr.size() - base, N_CFG);
        for (int k = 0; k < N_CFG && base + k < wr_addr.size(); k++) begin
            if (wr_addr[base + k] != 8'(N_CFG - k) || wr_data[base + k] != pat_byte(pat, k))
                bad++;
        end
        check_eq({tag, "_map"}, bad, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ok0, err0, k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ram_in",    ram_in, 0);
        check_eq("rst_addr",      ram_w_addr, 0);
        check_eq("rst_ram_write", ram_write, 1);
        check_eq("rst_ram_read",  ram_read, 1);
        check_eq("rst_busy",      busy, 0);
        check_eq("rst_flags",     {frame_ok, frame_err, err_code}, 0);
        rst = 1'b0;

        // Junk before a header is ignored; then a full load frame.
        send_byte(8'h55);
        send_byte(8'h01);
        check_eq("idle_busy", busy, 0);
        base = wr_addr.size(); ok0 = n_ok; err0 = n_err;
        send_load(0, 1'b0, -1);
        repeat (3) @(negedge clk);
        verify_load("load1", base, 0);
        check_eq("load1_first", {wr_addr[base], wr_data[base]}, {8'd112, 8'd1});
        check_eq("load1_last", {wr_addr[base + N_CFG - 1], wr_data[base + N_CFG - 1]}, {8'd1, 8'd112});
        check_eq("load1_ok", n_ok - ok0, 1);
        check_eq("load1_err", n_err - err0, 0);
        check_eq("load1_rr_after", ram_read, 1);
        check_eq("load1_busy", busy, 0);

        // Start frame.
        base = wr_addr.size(); ok0 = n_ok;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h02);
        repeat (3) @(negedge clk);
        check_eq("start_nwr", wr_addr.size() - base, 1);
        if (wr_addr.size() > base)
            check_eq("start_wr", {wr_addr[base], wr_data[base]}, {8'h00, 8'hFF});
        check_eq("start_ok", n_ok - ok0, 1);
        check_eq("start_code", err_code, 2'b00);

        // Bad command.
        base = wr_addr.size(); err0 = n_err;
        send_byte(8'hAA); send_byte(8'h05);
        repeat (3) @(negedge clk);
        check_eq("badcmd_err", n_err - err0, 1);
        check_eq("badcmd_code", err_code, 2'b01);
        check_eq("badcmd_nwr", wr_addr.size() - base, 0);
        check_eq("badcmd_busy", busy, 0);

        // Corrupted checksum.
        base = wr_addr.size(); ok0 = n_ok; err0 = n_err;
        send_load(0, 1'b1, -1);
        repeat (3) @(negedge clk);
        verify_load("badchk", base, 0);
        check_eq("badchk_err", n_err - err0, 1);
        check_eq("badchk_ok", n_ok - ok0, 0);
        check_eq("badchk_code", err_code, 2'b10);
        check_eq("badchk_rr", ram_read, 1);

        // Timeout after 10 payload bytes.
        base = wr_addr.size(); err0 = n_err;
        send_byte(8'hAA); send_byte(8'h01);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
        k = 0;
        while (k < 2 * GAP) begin
            @(posedge clk); #2;
            k++;
            if (frame_err) break;
        end
        check_eq("tmo_latency", k, GAP);
        check_eq("tmo_code", err_code, 2'b11);
        check_eq("tmo_nwr", wr_addr.size() - base, 10);
        @(negedge clk);
        check_eq("tmo_rr", ram_read, 1);
        ok0 = n_ok;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h02);
        repeat (3) @(negedge clk);
        check_eq("tmo_recover_ok", n_ok - ok0, 1);
        check_eq("tmo_recover_code", err_code, 2'b00);

        // Reset mid-payload, then a load with HDR inside the data and a
        // byte arriving on the exact gap boundary.
        send_byte(8'hAA); send_byte(8'h01);
        for (int i = 0; i < 50; i++) send_byte(8'(i + 1));
        check_eq("mid_rr_low", ram_read, 0);
        check_eq("mid_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rstmid_state", {busy, ram_write, ram_read}, 3'b011);
        @(negedge clk);
        rst = 1'b0;
        base = wr_addr.size(); ok0 = n_ok; err0 = n_err;
        send_load(1, 1'b0, 60);
        repeat (3) @(negedge clk);
        verify_load("reload", base, 1);
        check_eq("reload_ok", n_ok - ok0, 1);
        check_eq("reload_err", n_err - err0, 0);

        check_eq("rr_during_writes", n_rr_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
